minisrc_step_sequencer: RTL and testbench

//  Parametrised timing/step generator for the Mini SRC control path. Drives T-step count, fetch strobes,
//  the memory request handshake with wait-state stalls, halt/stop handling and an instruction counter.

---
 rtl/minisrc_step_sequencer.sv | 160 ++++++++++++++++
 tb/tb_minisrc_step_sequencer.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/minisrc_step_sequencer.sv
// T-step / fetch-execute sequencer for the Mini SRC control path.
// Optional single-step support is compiled in with `define SINGLE_STEP_EN.
module minisrc_step_sequencer #(
  parameter int unsigned            STEP_W   = 4,
  parameter int unsigned            OPC_W    = 5,
  parameter logic [OPC_W-1:0]       HALT_OPC = 5'b11011,
  parameter int unsigned            CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stop_i,
`ifdef SINGLE_STEP_EN
  input  logic              step_mode_i,
  input  logic              step_go_i,
`endif
  input  logic [OPC_W-1:0]  ir_opcode_i,
  input  logic [STEP_W-1:0] exec_steps_i,
  input  logic              exec_mem_req_i,
  input  logic              exec_mem_we_i,
  input  logic              mem_ready_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [STEP_W-1:0] step_o,
  output logic              ir_load_o,
  output logic              pc_inc_o,
  output logic              instr_done_o,
  output logic              run_o,
  output logic [CNT_W-1:0]  instr_count_o
);

  localparam int unsigned MAX_STEP = (2 ** STEP_W) - 1;

  typedef enum logic [2:0] {
    S_BOOT, S_F0, S_F1, S_F2, S_EX, S_HALT, S_STOP
  } state_e;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [STEP_W-1:0] last_q, last_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [STEP_W:0]   nExt, lastExt;
  logic [STEP_W-1:0] curLast;
  logic              pauseReq, resumeReq;
  logic              doneEvt, memReq, memWe;

  // Last execute step = 3 + n - 1, with n=0 promoted to 1 and clipped to the top step value.
  always_comb begin
    nExt = {1'b0, exec_steps_i};
    if (nExt == '0) nExt = (STEP_W+1)'(1);
    lastExt = nExt + (STEP_W+1)'(2);
    if (lastExt > (STEP_W+1)'(MAX_STEP)) lastExt = (STEP_W+1)'(MAX_STEP);
  end

`ifdef SINGLE_STEP_EN
  assign pauseReq  = stop_i || step_mode_i;
  assign resumeReq = !stop_i && (!step_mode_i || step_go_i);
`else
  assign pauseReq  = stop_i;
  assign resumeReq = !stop_i;
`endif

  // The decoder's length is only trusted on the first execute cycle; later steps use the latched copy.
  assign curLast = first_q ? lastExt[STEP_W-1:0] : last_q;

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    last_d  = last_q;
    first_d = 1'b0;
    cnt_d   = cnt_q;
    doneEvt = 1'b0;
    memReq  = 1'b0;
    memWe   = 1'b0;
    case (state_q)
      S_BOOT: begin
        state_d = S_F0;
        step_d  = '0;
      end
      S_F0: begin
        state_d = S_F1;
        step_d  = STEP_W'(1);
      end
      S_F1: begin
        memReq = 1'b1;
        if (mem_ready_i) begin
          state_d = S_F2;
          step_d  = STEP_W'(2);
        end
      end
      S_F2: begin
        state_d = S_EX;
        step_d  = STEP_W'(3);
        first_d = 1'b1;
      end
      S_EX: begin
        if (first_q) last_d = curLast;
        // A halt retires on its first execute cycle and never touches memory.
        if (first_q && (ir_opcode_i == HALT_OPC)) begin
          doneEvt = 1'b1;
          state_d = S_HALT;
          step_d  = '0;
        end else begin
          memReq = exec_mem_req_i;
          memWe  = exec_mem_we_i;
          if (!(exec_mem_req_i && !mem_ready_i)) begin
            if (step_q == curLast) begin
              doneEvt = 1'b1;
              state_d = pauseReq ? S_STOP : S_F0;
              step_d  = '0;
            end else begin
              step_d = step_q + STEP_W'(1);
            end
          end else begin
            first_d = first_q;
          end
        end
      end
      S_STOP: begin
        if (resumeReq) state_d = S_F0;
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_BOOT;
        step_d  = '0;
      end
    endcase
    if (doneEvt) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_BOOT;
      step_q  <= '0;
      last_q  <= '0;
      first_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      last_q  <= last_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mem_req_o     = memReq;
  assign mem_we_o      = memWe;
  assign instr_done_o  = doneEvt;
  assign step_o        = step_q;
  assign pc_inc_o      = (state_q == S_F0);
  assign ir_load_o     = (state_q == S_F2);
  assign run_o         = (state_q == S_F0) || (state_q == S_F1) ||
                         (state_q == S_F2) || (state_q == S_EX);
  assign instr_count_o = cnt_q;

endmodule

// File: tb/tb_minisrc_step_sequencer.sv
// Directed bench for minisrc_step_sequencer (CNT_W=4 so counter wrap is reachable quickly).
module tb_minisrc_step_sequencer;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       stop_i;
  logic [4:0] ir_opcode_i;
  logic [3:0] exec_steps_i;
  logic       exec_mem_req_i, exec_mem_we_i, mem_ready_i;
  logic       mem_req_o, mem_we_o, ir_load_o, pc_inc_o, instr_done_o, run_o;
  logic [3:0] step_o;
  logic [3:0] instr_count_o;

  int checkCount = 0;
  int errorCount = 0;

  minisrc_step_sequencer #(.STEP_W(4), .OPC_W(5), .HALT_OPC(5'b11011), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stop_i(stop_i),
`ifdef SINGLE_STEP_EN
    .step_mode_i(1'b0), .step_go_i(1'b0),
`endif
    .ir_opcode_i(ir_opcode_i), .exec_steps_i(exec_steps_i),
    .exec_mem_req_i(exec_mem_req_i), .exec_mem_we_i(exec_mem_we_i),
    .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .step_o(step_o), .ir_load_o(ir_load_o), .pc_inc_o(pc_inc_o),
    .instr_done_o(instr_done_o), .run_o(run_o), .instr_count_o(instr_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic stop, input logic [3:0] steps, input logic [4:0] opc,
                               input logic xreq, input logic xwe, input logic ready);
    stop_i         = stop;
    exec_steps_i   = steps;
    ir_opcode_i    = opc;
    exec_mem_req_i = xreq;
    exec_mem_we_i  = xwe;
    mem_ready_i    = ready;
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  int pulses;
  int strobeSeen;
  logic [3:0] doneStep;

  initial begin
    rst_i = 1'b1;
    applyStimulus(1'b0, 4'd2, 5'd0, 1'b0, 1'b0, 1'b1);
    tick(); tick();
    checkOutput("rst_step", step_o, 0);
    checkOutput("rst_run", run_o, 0);
    checkOutput("rst_memreq", mem_req_o, 0);
    checkOutput("rst_pcinc", pc_inc_o, 0);
    checkOutput("rst_done", instr_done_o, 0);
    checkOutput("rst_count", instr_count_o, 0);

    // Basic instruction, exec_steps=2: steps 0,1,2,3,4,0
    rst_i = 1'b0;
    tick(); checkOutput("t1_step0", step_o, 0); checkOutput("t1_pcinc", pc_inc_o, 1); checkOutput("t1_run", run_o, 1);
    tick(); checkOutput("t1_step1", step_o, 1); checkOutput("t1_memreq", mem_req_o, 1); checkOutput("t1_memwe", mem_we_o, 0);
    tick(); checkOutput("t1_step2", step_o, 2); checkOutput("t1_irload", ir_load_o, 1);
    tick(); checkOutput("t1_step3", step_o, 3); checkOutput("t1_done3", instr_done_o, 0);
    tick(); checkOutput("t1_step4", step_o, 4); checkOutput("t1_done4", instr_done_o, 1);
    tick(); checkOutput("t1_stepF0", step_o, 0); checkOutput("t1_count", instr_count_o, 1);

    // Fetch wait states: ready low for 3 F1 cycles
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t2_stall_step", step_o, 1);
      checkOutput("t2_stall_req", mem_req_o, 1);
    end
    tick(); checkOutput("t2_req4", mem_req_o, 1); checkOutput("t2_irload_early", ir_load_o, 0);
    mem_ready_i = 1'b1;
    tick(); checkOutput("t2_irload", ir_load_o, 1); checkOutput("t2_req_drop", mem_req_o, 0);

    // Execute-phase write with two wait cycles
    applyStimulus(1'b0, 4'd2, 5'd0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("t3_hold_step", step_o, 3);
      checkOutput("t3_memwe", mem_we_o, 1);
      checkOutput("t3_hold_done", instr_done_o, 0);
    end
    mem_ready_i = 1'b1;
    tick(); checkOutput("t3_step4", step_o, 4); checkOutput("t3_done", instr_done_o, 1);
    applyStimulus(1'b0, 4'd3, 5'd0, 1'b0, 1'b0, 1'b1);
    tick(); checkOutput("t3_count", instr_count_o, 2); checkOutput("t3_f0", pc_inc_o, 1);

    // Stop raised mid-instruction does not truncate it
    tick(); tick(); tick();
    checkOutput("t4_step3", step_o, 3);
    stop_i = 1'b1;
    tick(); checkOutput("t4_step4", step_o, 4); checkOutput("t4_done4", instr_done_o, 0);
    tick(); checkOutput("t4_step5", step_o, 5); checkOutput("t4_done5", instr_done_o, 1);
    tick(); checkOutput("t4_run_stop", run_o, 0); checkOutput("t4_step_stop", step_o, 0);
    tick(); checkOutput("t4_still_stop", run_o, 0); checkOutput("t4_no_pcinc", pc_inc_o, 0);
    stop_i = 1'b0;
    tick(); checkOutput("t4_resume_run", run_o, 1); checkOutput("t4_resume_pcinc", pc_inc_o, 1);
    checkOutput("t4_count", instr_count_o, 3);

    // 17 instructions with exec_steps=0 (treated as 1): count wraps 3+17 -> 4
    exec_steps_i = 4'd0;
    pulses = 0;
    for (int i = 0; i < 200 && pulses < 17; i++) begin
      tick();
      if (instr_done_o) begin
        pulses++;
        checkOutput("t5_done_step", step_o, 3);
      end
    end
    checkOutput("t5_pulses", pulses, 17);
    tick(); checkOutput("t5_count_wrap", instr_count_o, 4);

    // exec_steps=15 saturates so the last step is 15
    exec_steps_i = 4'd15;
    doneStep = 4'd0;
    pulses = 0;
    for (int i = 0; i < 100 && pulses < 1; i++) begin
      tick();
      if (instr_done_o) begin
        pulses++;
        doneStep = step_o;
      end
    end
    checkOutput("t6_pulses", pulses, 1);
    checkOutput("t6_sat_step", doneStep, 15);
    tick(); checkOutput("t6_count", instr_count_o, 5);

    // Asynchronous reset while in F1
    tick(); checkOutput("t7_in_f1", mem_req_o, 1);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("t7_memreq", mem_req_o, 0);
    checkOutput("t7_step", step_o, 0);
    checkOutput("t7_run", run_o, 0);
    checkOutput("t7_count", instr_count_o, 0);

    // HALT opcode
    tick();
    applyStimulus(1'b0, 4'd2, 5'b11011, 1'b0, 1'b0, 1'b1);
    rst_i = 1'b0;
    tick(); tick(); tick(); tick();
    checkOutput("t8_halt_done", instr_done_o, 1);
    checkOutput("t8_halt_step", step_o, 3);
    tick(); checkOutput("t8_run", run_o, 0); checkOutput("t8_count", instr_count_o, 1);
    strobeSeen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (run_o || pc_inc_o || ir_load_o || mem_req_o || instr_done_o || step_o != 4'd0) strobeSeen++;
    end
    checkOutput("t8_quiet", strobeSeen, 0);
    rst_i = 1'b1;
    tick(); checkOutput("t8_reset_count", instr_count_o, 0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
